// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit and instruction memory.
// The fetch unit is the master (drives request and address); the memory is the slave.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: sequential PC generation, in-order memory
// requests, a small prefetch FIFO feeding decode, and redirect handling that
// discards buffered and in-flight wrong-path words.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds misalign_o and blocks
// fetching after a redirect to a non-word-aligned target; without it the two
// low target bits are simply cleared.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     imem,
    input  logic             pc_sel_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic             stall_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             inst_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic             misalign_o
`endif
);

    localparam int          PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] drop_next;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc   [FIFO_DEPTH];

    logic [XLEN-1:0] target_aligned;
    logic [CNT_W:0]  inflight;
    logic            room;
    logic            granted;
    logic            resp;
    logic            push;
    logic            resp_drop;
    logic            empty;
    logic            pop;
    logic            blocked;

    assign target_aligned = {target_i[XLEN-1:2], 2'b00};
    assign inflight       = {1'b0, count} + {1'b0, outstanding};
    assign room           = inflight < (CNT_W + 1)'(FIFO_DEPTH);
    assign granted        = imem.imem_req_o && imem.imem_gnt_i;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp           = imem.imem_rvalid_i && (outstanding != '0);
    assign resp_drop      = resp && (drop != '0);
    // Words arriving in a redirect cycle are wrong-path even when drop is still 0.
    assign push           = resp && (drop == '0) && !pc_sel_i;
    assign empty          = (count == '0);
    assign pop            = !empty && !stall_i && !pc_sel_i;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;

    // Misalign flag follows the alignment of the most recent redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (pc_sel_i) begin
            misalign <= (target_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign;
    assign blocked    = misalign;
`else
    logic unused_target_lsb;

    assign unused_target_lsb = ^target_i[1:0];
    assign blocked           = 1'b0;
`endif

    // Counter bookkeeping: drop snapshots everything still in flight on a redirect.
    always_comb begin
        outstanding_next = outstanding + CNT_W'(granted) - CNT_W'(resp);
        drop_next        = drop - CNT_W'(resp_drop);
        if (pc_sel_i) begin
            drop_next = outstanding_next;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state: FLUSH only while wrong-path responses remain to be discarded.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   state_next = (pc_sel_i && (outstanding_next != '0)) ? FLUSH : FETCH;
            FLUSH:   state_next = (drop_next != '0) ? FLUSH : FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Request generation: gated by buffer space, redirect, misalign block and reset.
    always_comb begin
        imem.imem_req_o = 1'b0;
        case (state)
            FETCH:   imem.imem_req_o = room && !pc_sel_i && !blocked && !rst;
            FLUSH:   imem.imem_req_o = 1'b0;
            default: imem.imem_req_o = 1'b0;
        endcase
    end

    assign imem.imem_addr_o = fetch_pc;

    // Fetch/response PCs, in-flight counters and FIFO occupancy/pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop        <= drop_next;
            if (pc_sel_i) begin
                fetch_pc <= target_aligned;
                resp_pc  <= target_aligned;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (granted) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage: written on every accepted right-path response.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= imem.imem_rdata_i;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    // When empty, decode sees a NOP and the PC of the next expected word.
    assign inst_valid_o = !empty;
    assign inst_o       = empty ? NOP : fifo_inst[rd_ptr];
    assign pc_o         = empty ? resp_pc : fifo_pc[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an in-order instruction memory model
// of configurable latency.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pc_sel;
    logic [31:0] target;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks;
    int errors;
    int cyc;
    int lat;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (bus),
        .pc_sel_i     (pc_sel),
        .target_i     (target),
        .stall_i      (stall),
        .inst_o       (inst),
        .pc_o         (pc),
        .inst_valid_o (inst_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_o   (misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h0000_016F ^ {a[23:0], 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: record this cycle's grant, advance, present any due response.
    task automatic tick();
        @(negedge clk);
        if (bus.imem_req_o && bus.imem_gnt_i) begin
            pend_addr.push_back(bus.imem_addr_o);
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = word_at(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = 32'h0;
        end
    endtask

    task automatic clear_mem();
        pend_addr.delete();
        pend_due.delete();
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
    endtask

    task automatic do_reset(input int l);
        lat    = l;
        rst    = 1'b1;
        stall  = 1'b0;
        pc_sel = 1'b0;
        clear_mem();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        stall  = 1'b0;
        pc_sel = 1'b0;
        target = 32'h0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        lat    = 1;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;

        // Reset values
        tick();
        tick();
        chk("rst_req",   32'(bus.imem_req_o), 32'h0);
        chk("rst_addr",  bus.imem_addr_o,     32'h0);
        chk("rst_valid", 32'(inst_valid),     32'h0);
        chk("rst_inst",  inst,                32'h0000_0013);
        chk("rst_pc",    pc,                  32'h0);

        // Sequential fetch, 1-cycle memory
        rst = 1'b0;
        #1;
        chk("seq_req0",  32'(bus.imem_req_o), 32'h1);
        chk("seq_addr0", bus.imem_addr_o,     32'h0);
        tick(); #1;
        chk("seq_addr1",  bus.imem_addr_o,     32'h4);
        chk("seq_valid1", 32'(inst_valid),     32'h0);
        tick(); #1;
        chk("seq_valid2", 32'(inst_valid),     32'h1);
        chk("seq_pc2",    pc,                  32'h0);
        chk("seq_inst2",  inst,                32'h0000_016F);
        chk("seq_req2",   32'(bus.imem_req_o), 32'h0);
        chk("seq_addr2",  bus.imem_addr_o,     32'h8);

        // Backpressure: stall for four cycles
        tick(); stall = 1'b1; #1;
        chk("bp_req3",  32'(bus.imem_req_o), 32'h1);
        chk("bp_addr3", bus.imem_addr_o,     32'h8);
        chk("bp_pc3",   pc,                  32'h4);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("bp_req_hold", 32'(bus.imem_req_o), 32'h0);
            chk("bp_pc_hold",  pc,                  32'h4);
        end
        chk("bp_inst_hold", inst, word_at(32'h4));
        tick(); stall = 1'b0; #1;
        chk("bp_rel_pc0", pc, 32'h4);
        tick(); #1;
        chk("bp_rel_pc1",   pc,                  32'h8);
        chk("bp_rel_inst1", inst,                word_at(32'h8));
        chk("bp_rel_req",   32'(bus.imem_req_o), 32'h1);
        chk("bp_rel_addr",  bus.imem_addr_o,     32'hC);

        // Reset with a full FIFO
        stall = 1'b1;
        tick(); #1;
        tick(); #1;
        chk("full_pc",  pc,                  32'h8);
        chk("full_req", 32'(bus.imem_req_o), 32'h0);
        rst = 1'b1;
        tick(); #1;
        chk("mrst_valid", 32'(inst_valid),     32'h0);
        chk("mrst_addr",  bus.imem_addr_o,     32'h0);
        chk("mrst_req",   32'(bus.imem_req_o), 32'h0);
        rst   = 1'b0;
        stall = 1'b0;
        clear_mem();
        #1;
        chk("mrst_restart_req",  32'(bus.imem_req_o), 32'h1);
        chk("mrst_restart_addr", bus.imem_addr_o,     32'h0);
        tick(); #1;
        chk("mrst_restart_addr1", bus.imem_addr_o, 32'h4);
        tick(); #1;
        chk("mrst_restart_pc",   pc,   32'h0);
        chk("mrst_restart_inst", inst, 32'h0000_016F);

        // Redirect with two outstanding, 3-cycle memory
        do_reset(3);
        tick(); #1;
        tick();
        pc_sel = 1'b1;
        target = 32'h100;
        #1;
        chk("rd_req_forced", 32'(bus.imem_req_o), 32'h0);
        tick(); pc_sel = 1'b0; #1;
        chk("rd_flush_valid0", 32'(inst_valid),     32'h0);
        chk("rd_flush_req0",   32'(bus.imem_req_o), 32'h0);
        tick(); #1;
        chk("rd_flush_valid1", 32'(inst_valid),     32'h0);
        chk("rd_flush_req1",   32'(bus.imem_req_o), 32'h0);
        tick(); #1;
        chk("rd_refetch_req",  32'(bus.imem_req_o), 32'h1);
        chk("rd_refetch_addr", bus.imem_addr_o,     32'h100);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("rd_wait_valid", 32'(inst_valid), 32'h0);
        end
        tick(); #1;
        chk("rd_valid", 32'(inst_valid), 32'h1);
        chk("rd_pc",    pc,              32'h100);
        chk("rd_inst",  inst,            word_at(32'h100));

        // Redirect in the cycle that would grant 0x8, with stall held
        do_reset(1);
        tick(); #1;
        tick(); #1;
        tick();
        stall  = 1'b1;
        pc_sel = 1'b1;
        target = 32'h100;
        #1;
        chk("rg_req_forced", 32'(bus.imem_req_o), 32'h0);
        tick(); pc_sel = 1'b0; #1;
        chk("rg_valid_next", 32'(inst_valid),     32'h0);
        chk("rg_addr_next",  bus.imem_addr_o,     32'h100);
        chk("rg_req_next",   32'(bus.imem_req_o), 32'h1);
        tick(); #1;
        tick(); #1;
        chk("rg_valid", 32'(inst_valid), 32'h1);
        chk("rg_pc",    pc,              32'h100);
        chk("rg_inst",  inst,            word_at(32'h100));
        stall = 1'b0;

        // Unaligned redirect target
        do_reset(1);
        pc_sel = 1'b1;
        target = 32'h102;
        #1;
        chk("ua_req_forced", 32'(bus.imem_req_o), 32'h0);
        tick(); pc_sel = 1'b0; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("ua_misalign", 32'(misalign),        32'h1);
        chk("ua_blocked",  32'(bus.imem_req_o),  32'h0);
        tick(); #1;
        chk("ua_blocked_hold", 32'(bus.imem_req_o), 32'h0);
        pc_sel = 1'b1;
        target = 32'h200;
        tick(); pc_sel = 1'b0; #1;
        chk("ua_clear",      32'(misalign),        32'h0);
        chk("ua_clear_req",  32'(bus.imem_req_o),  32'h1);
        chk("ua_clear_addr", bus.imem_addr_o,      32'h200);
`else
        chk("ua_req",  32'(bus.imem_req_o), 32'h1);
        chk("ua_addr", bus.imem_addr_o,     32'h100);
        tick(); #1;
        tick(); #1;
        chk("ua_valid", 32'(inst_valid), 32'h1);
        chk("ua_pc",    pc,              32'h100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
